// File: rtl/gap_pkg.sv
// ---------------------------------------------------------------------------
// gap_pkg
// Shared constants and types for the global-average-pooling datapath. The
// lane packer and the downstream averager both import this package, so the
// lane count, activation width and frame length are kept consistent.
//   GAP_LANES     : activations packed per output word
//   GAP_DW        : bits per activation
//   GAP_FRAME_LEN : elements per frame (the averager divides by >>12)
//   GAP_WORD_W    : packed word width (GAP_LANES * GAP_DW)
//   gap_state_e   : packer control states
// ---------------------------------------------------------------------------
package gap_pkg;

  localparam int GAP_LANES     = 9;
  localparam int GAP_DW        = 10;
  localparam int GAP_FRAME_LEN = 4096;
  localparam int GAP_WORD_W    = GAP_LANES * GAP_DW;

  // Counter widths: lane index 0..8, element count 0..4096
  localparam int GAP_LANE_CW   = 4;
  localparam int GAP_ELEM_CW   = 13;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } gap_state_e;

endpackage

// File: rtl/gap_lane_buf.sv
// ---------------------------------------------------------------------------
// gap_lane_buf
// GAP_LANES x GAP_DW register bank. Decodes a lane index into per-lane write
// enables and supports a synchronous clear that takes priority over a write.
// The packed word output already includes any write presented this cycle, so
// the caller can register a complete word on the same edge that fills the
// last lane (while the bank itself is cleared).
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_we           : write i_data into lane i_lane
//   i_lane         : target lane index
//   i_data         : activation to store
//   i_clr          : clear all lanes on the next edge
//   o_word         : bank contents with the pending write merged in,
//                    lane k at [k*GAP_DW +: GAP_DW]
// ---------------------------------------------------------------------------
module gap_lane_buf
  import gap_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_we,
  input  logic [GAP_LANE_CW-1:0] i_lane,
  input  logic [GAP_DW-1:0]      i_data,
  input  logic                   i_clr,
  output logic [GAP_WORD_W-1:0]  o_word
);

  logic [GAP_DW-1:0]    bank_q [GAP_LANES];
  logic [GAP_DW-1:0]    bank_d [GAP_LANES];
  logic [GAP_LANES-1:0] lane_sel;

  always_comb begin
    for (int k = 0; k < GAP_LANES; k++) begin
      lane_sel[k] = i_we && (i_lane == GAP_LANE_CW'(k));
    end
  end

  // Merge the in-flight write into the outgoing word; clear wins over write
  // in the stored bank so a completed word leaves an empty buffer behind.
  always_comb begin
    o_word = '0;
    for (int k = 0; k < GAP_LANES; k++) begin
      bank_d[k] = bank_q[k];
      o_word[k*GAP_DW +: GAP_DW] = lane_sel[k] ? i_data : bank_q[k];
      if (i_clr) begin
        bank_d[k] = '0;
      end else if (lane_sel[k]) begin
        bank_d[k] = i_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < GAP_LANES; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < GAP_LANES; k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

endmodule

// File: rtl/gap_lane_packer.sv
// ---------------------------------------------------------------------------
// gap_lane_packer
// Packs one activation per accepted cycle into GAP_LANES-lane words for the
// global-average-pooling accumulator. The accumulator adds its input every
// clock, so o_data is forced to zero whenever o_valid is low. Enforces a
// fixed frame of GAP_FRAME_LEN elements, reports frame completion on o_done
// and framing problems on the sticky o_err.
//
// Build option:
//   GAP_PACK_FLUSH_EN defined   : a partial tail word is zero-padded and
//                                 emitted from a FLUSH state before DONE.
//   GAP_PACK_FLUSH_EN undefined : no FLUSH state; a partial tail word is
//                                 dropped, o_done pulses the cycle after the
//                                 final accept and o_err is raised.
//
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_valid/o_ready: input handshake, accept = i_valid & o_ready
//   i_data         : unsigned activation
//   i_last         : final element of a frame (qualified by accept)
//   i_start        : re-arm pulse, honoured only in DONE
//   o_valid/o_data : registered packed word, zero when not valid
//   o_done         : one-cycle pulse after the frame's last word
//   o_err          : sticky framing error
// ---------------------------------------------------------------------------
module gap_lane_packer
  import gap_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [GAP_DW-1:0]     i_data,
  input  logic                  i_last,
  input  logic                  i_start,
  output logic                  o_valid,
  output logic [GAP_WORD_W-1:0] o_data,
  output logic                  o_done,
  output logic                  o_err
);

  gap_state_e              state_q, state_d;
  logic [GAP_LANE_CW-1:0]  lane_cnt_q, lane_cnt_d;
  logic [GAP_ELEM_CW-1:0]  elem_cnt_q, elem_cnt_d;
  logic                    valid_q, valid_d;
  logic [GAP_WORD_W-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    last_elem;
  logic                    word_full;
  logic                    drop_done;
  logic                    buf_clr;
  logic [GAP_WORD_W-1:0]   buf_word;

  assign o_ready = (state_q == ST_FILL);
  assign accept  = i_valid && o_ready;

  gap_lane_buf u_lane_buf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (accept),
    .i_lane  (lane_cnt_q),
    .i_data  (i_data),
    .i_clr   (buf_clr),
    .o_word  (buf_word)
  );

  // Frame control: counts lanes and elements, emits full words, decides how
  // the frame ends and records framing errors.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    elem_cnt_d = elem_cnt_q;
    valid_d    = 1'b0;
    data_d     = '0;
    err_d      = err_q;
    buf_clr    = 1'b0;
    drop_done  = 1'b0;
    last_elem  = ((elem_cnt_q + 13'd1) == GAP_ELEM_CW'(GAP_FRAME_LEN));
    word_full  = (lane_cnt_q == GAP_LANE_CW'(GAP_LANES - 1));

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          elem_cnt_d = elem_cnt_q + 13'd1;
          if (word_full) begin
            lane_cnt_d = '0;
            valid_d    = 1'b1;
            data_d     = buf_word;
            buf_clr    = 1'b1;
          end else begin
            lane_cnt_d = lane_cnt_q + 4'd1;
          end

          // An early i_last and a missing i_last at the frame boundary are
          // both framing errors; either way the frame is wrapped up.
          if (i_last != last_elem) begin
            err_d = 1'b1;
          end

          if (i_last || last_elem) begin
            if (word_full) begin
              state_d = ST_DONE;
            end else begin
`ifdef GAP_PACK_FLUSH_EN
              state_d = ST_FLUSH;
`else
              state_d   = ST_DONE;
              buf_clr   = 1'b1;
              drop_done = 1'b1;
              err_d     = 1'b1;
`endif
            end
          end
        end
      end

`ifdef GAP_PACK_FLUSH_EN
      // Unfilled lanes are already zero because the bank is cleared after
      // every emitted word.
      ST_FLUSH: begin
        valid_d = 1'b1;
        data_d  = buf_word;
        buf_clr = 1'b1;
        state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        if (i_start) begin
          state_d    = ST_FILL;
          lane_cnt_d = '0;
          elem_cnt_d = '0;
          err_d      = 1'b0;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // o_done follows the frame's final word by one cycle: the only time a word
  // is still on the output while already in DONE is right after that word.
  always_comb begin
    done_d = ((state_q == ST_DONE) && valid_q) || drop_done;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_FILL;
      lane_cnt_q <= '0;
      elem_cnt_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      elem_cnt_q <= elem_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_gap_lane_packer.sv
// ---------------------------------------------------------------------------
// tb_gap_lane_packer
// Directed self-checking bench for gap_lane_packer. Expectations for the
// frame tail follow the GAP_PACK_FLUSH_EN build option.
// ---------------------------------------------------------------------------
module tb_gap_lane_packer;

  logic        i_clk;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [9:0]  i_data;
  logic        i_last;
  logic        i_start;
  logic        o_valid;
  logic [89:0] o_data;
  logic        o_done;
  logic        o_err;

  int tests_run;
  int tests_failed;

  gap_lane_packer dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_start (i_start),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one rising edge and settle so registered outputs can be sampled.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_start = 1'b0;
    i_data  = 10'd0;
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (o_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", o_ready); end
    tests_run++;
    if (o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
    tests_run++;
    if (o_data !== 90'd0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 0", o_data); end
    tests_run++;
    if (o_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", o_done); end
    tests_run++;
    if (o_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", o_err); end
  endtask

  task automatic test_full_frame();
    int words;
    int bad_words;
    int bad_idle;
    int done_early;
    logic [89:0] ones_w;
    ones_w = '0;
    for (int k = 0; k < 9; k++) ones_w[k*10 +: 10] = 10'd1;
    words = 0; bad_words = 0; bad_idle = 0; done_early = 0;
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      i_valid = 1'b1;
      i_data  = 10'd1;
      i_last  = (i == 4095);
      step();
      if (o_valid === 1'b1) begin
        words++;
        if (o_data !== ones_w) bad_words++;
      end else if (o_data !== 90'd0) begin
        bad_idle++;
      end
      if (i < 4095 && o_done !== 1'b0) done_early++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    tests_run++;
    if (words != 455) begin tests_failed++; $display("[TB] FAIL frame_word_count: got %0d expected 455", words); end
    tests_run++;
    if (bad_words != 0) begin tests_failed++; $display("[TB] FAIL frame_word_data: %0d words differ from all-ones lanes", bad_words); end
    tests_run++;
    if (bad_idle != 0) begin tests_failed++; $display("[TB] FAIL frame_idle_zero: %0d idle cycles had nonzero o_data", bad_idle); end
    tests_run++;
    if (done_early != 0) begin tests_failed++; $display("[TB] FAIL frame_done_early: %0d early o_done pulses, expected 0", done_early); end
`ifdef GAP_PACK_FLUSH_EN
    tests_run++;
    if (o_valid !== 1'b0 || o_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_tail_t1: valid=%b done=%b expected 0 0", o_valid, o_done); end
    step();
    tests_run++;
    if (o_valid !== 1'b1 || o_data !== 90'd1) begin tests_failed++; $display("[TB] FAIL frame_tail_word: valid=%b data=%h expected 1 %h", o_valid, o_data, 90'd1); end
    step();
    tests_run++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_tail_done: done=%b valid=%b expected 1 0", o_done, o_valid); end
    tests_run++;
    if (o_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_err: got %b expected 0", o_err); end
`else
    tests_run++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_drop_done: done=%b valid=%b expected 1 0", o_done, o_valid); end
    step();
    tests_run++;
    if (o_valid !== 1'b0 || o_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_drop_after: valid=%b done=%b expected 0 0", o_valid, o_done); end
    tests_run++;
    if (o_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL frame_err: got %b expected 1", o_err); end
`endif
    tests_run++;
    if (o_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_done_ready: got %b expected 0", o_ready); end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    tests_run++;
    if (o_ready !== 1'b1 || o_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL frame_restart: ready=%b err=%b expected 1 0", o_ready, o_err); end
  endtask

  task automatic test_back_to_back();
    logic [89:0] w0;
    logic [89:0] w1;
    int bad_idle;
    w0 = '0;
    w1 = '0;
    for (int k = 0; k < 9; k++) begin
      w0[k*10 +: 10] = 10'(k);
      w1[k*10 +: 10] = 10'(9 + k);
    end
    bad_idle = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      i_valid = 1'b1;
      i_data  = 10'(i);
      i_last  = 1'b0;
      step();
      if (i == 8) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_data !== w0) begin tests_failed++; $display("[TB] FAIL b2b_word0: valid=%b data=%h expected 1 %h", o_valid, o_data, w0); end
      end else if (i == 17) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_data !== w1) begin tests_failed++; $display("[TB] FAIL b2b_word1: valid=%b data=%h expected 1 %h", o_valid, o_data, w1); end
      end else if (o_valid !== 1'b0 || o_data !== 90'd0 || o_ready !== 1'b1) begin
        bad_idle++;
      end
    end
    i_valid = 1'b0;
    tests_run++;
    if (bad_idle != 0) begin tests_failed++; $display("[TB] FAIL b2b_between: %0d cycles with unexpected output or ready low", bad_idle); end
  endtask

  task automatic test_early_last();
    logic [89:0] w0;
    logic [89:0] w1;
    logic [89:0] wp;
    int bad_hold;
    w0 = '0;
    w1 = '0;
    wp = '0;
    for (int k = 0; k < 9; k++) begin
      w0[k*10 +: 10] = 10'(100 + k);
      w1[k*10 +: 10] = 10'(109 + k);
    end
    wp[9:0]   = 10'd118;
    wp[19:10] = 10'd119;
    bad_hold = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1;
      i_data  = 10'(100 + i);
      i_last  = (i == 19);
      step();
      if (i == 8) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_data !== w0) begin tests_failed++; $display("[TB] FAIL early_word0: valid=%b data=%h expected 1 %h", o_valid, o_data, w0); end
      end
      if (i == 17) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_data !== w1) begin tests_failed++; $display("[TB] FAIL early_word1: valid=%b data=%h expected 1 %h", o_valid, o_data, w1); end
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
`ifdef GAP_PACK_FLUSH_EN
    tests_run++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_flush_state: valid=%b ready=%b expected 0 0", o_valid, o_ready); end
    step();
    tests_run++;
    if (o_valid !== 1'b1 || o_data !== wp) begin tests_failed++; $display("[TB] FAIL early_partial: valid=%b data=%h expected 1 %h", o_valid, o_data, wp); end
    step();
    tests_run++;
    if (o_done !== 1'b1) begin tests_failed++; $display("[TB] FAIL early_done: got %b expected 1", o_done); end
`else
    tests_run++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_drop_done: done=%b valid=%b expected 1 0", o_done, o_valid); end
    step();
`endif
    tests_run++;
    if (o_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL early_err: got %b expected 1", o_err); end
    // Data offered while in DONE must be ignored and the packer stays parked.
    i_valid = 1'b1;
    i_data  = 10'd55;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_done !== 1'b0) bad_hold++;
    end
    i_valid = 1'b0;
    tests_run++;
    if (bad_hold != 0) begin tests_failed++; $display("[TB] FAIL early_hold: %0d cycles left DONE or emitted output", bad_hold); end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    tests_run++;
    if (o_ready !== 1'b1 || o_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL early_restart: ready=%b err=%b expected 1 0", o_ready, o_err); end
  endtask

  task automatic test_gaps();
    logic [89:0] w;
    int bad_idle;
    int gap;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*10 +: 10] = 10'(200 + k);
    bad_idle = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        i_valid = 1'b0;
        i_data  = 10'($urandom_range(0, 1023));
        i_start = (i == 4);
        step();
        i_start = 1'b0;
        if (o_valid !== 1'b0 || o_data !== 90'd0) bad_idle++;
      end
      i_valid = 1'b1;
      i_data  = 10'(200 + i);
      step();
      if (i < 8 && (o_valid !== 1'b0 || o_data !== 90'd0)) bad_idle++;
      i_valid = 1'b0;
      i_data  = 10'd777;
      if (i == 8) begin
        tests_run++;
        if (o_valid !== 1'b1 || o_data !== w) begin tests_failed++; $display("[TB] FAIL gaps_word: valid=%b data=%h expected 1 %h", o_valid, o_data, w); end
      end
    end
    step();
    if (o_valid !== 1'b0 || o_data !== 90'd0) bad_idle++;
    tests_run++;
    if (bad_idle != 0) begin tests_failed++; $display("[TB] FAIL gaps_idle_zero: %0d non-valid cycles with output activity", bad_idle); end
  endtask

  task automatic test_reset_mid();
    logic [89:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*10 +: 10] = 10'(300 + k);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data  = 10'(50 + i);
      step();
    end
    i_valid = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    tests_run++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 90'd0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: ready=%b valid=%b data=%h done=%b err=%b expected 1 0 0 0 0", o_ready, o_valid, o_data, o_done, o_err);
    end
    step();
    i_reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      i_valid = 1'b1;
      i_data  = 10'(300 + i);
      step();
    end
    i_valid = 1'b0;
    tests_run++;
    if (o_valid !== 1'b1 || o_data !== w) begin tests_failed++; $display("[TB] FAIL midreset_word: valid=%b data=%h expected 1 %h", o_valid, o_data, w); end
    // Asynchronous clear of a word that is currently on the output.
    #2;
    i_reset = 1'b1;
    #1;
    tests_run++;
    if (o_valid !== 1'b0 || o_data !== 90'd0) begin tests_failed++; $display("[TB] FAIL async_reset_word: valid=%b data=%h expected 0 0", o_valid, o_data); end
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_start = 1'b0;
    i_data  = 10'd0;
    test_reset();
    test_back_to_back();
    test_early_last();
    test_gaps();
    test_reset_mid();
    test_full_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
